time_display_driver: RTL
========================

Name: time_display_driver

Overview:
- Display-side consumer of the alarm clock's time outputs.
- Drives the six seven-segment digits HH MM SS from either the running time (hr/min/sec) or the alarm time (hrA/minA/secA).
- Converts each 8-bit binary field to two BCD digits with a sequential shift-add-3 converter, then commits all six digits atomically once per frame.
- Blinks the whole display while the alarm output is asserted.

Parameters:
- BLINK_CYCLES, 25_000_000: clk cycles per blink half-period. Benches use 4.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- sec  input  8  running seconds, binary
- min  input  8  running minutes, binary
- hr  input  8  running hours, binary
- secA  input  8  alarm seconds, binary
- minA  input  8  alarm minutes, binary
- hrA  input  8  alarm hours, binary
- show_alarm  input  1  1 = display the alarm fields, 0 = display the running time
- alarm  input  1  alarm ringing; enables blinking
- HEX0  output  7  seconds ones digit
- HEX1  output  7  seconds tens digit
- HEX2  output  7  minutes ones digit
- HEX3  output  7  minutes tens digit
- HEX4  output  7  hours ones digit
- HEX5  output  7  hours tens digit
- frame_done  output  1  one-cycle pulse on the cycle the new digits appear

Behaviour:
- Interface:
  - One clock, clk.
  - reset is synchronous and active-low: sampled only on the clk rising edge, with 0 = reset.
- Reset (reset=0 at an edge):
  - HEX0..HEX5 = 7'h7F (blank).
  - frame_done = 0.
  - FSM goes to LATCH; blink counter = 0; blink phase = 0 (visible).
  - Reset overrides everything, including a conversion in progress.
- Segment encoding:
  - Bit order gfedcba, active-low.
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
  - Dash = 3F; blank = 7F.
- FSM states: LATCH -> SHIFT -> COMMIT -> LATCH. Free-running, no idle state.
  - LATCH (1 cycle):
    - Capture the triple selected by show_alarm into working registers.
    - Clear the BCD accumulators; shift count = 0.
  - SHIFT (exactly 8 cycles):
    - All three fields convert in parallel.
    - Each cycle: add 3 to any BCD nibble >= 5, then shift left one bit, taking the binary MSB into the BCD LSB.
    - Leave after the count reaches 7.
  - COMMIT (1 cycle):
    - Encode each field to a digit pair.
    - If the field value > 99, both digits of that field are dash (3F); the hundreds nibble is used only for this test.
    - Write the digit registers; assert frame_done on the following cycle, coincident with the HEX update.
- Timing:
  - Frame length = 10 cycles.
  - Inputs are sampled at the end of LATCH and appear on HEX one edge after COMMIT.
  - Input changes during SHIFT/COMMIT do not affect the current frame.
  - show_alarm toggling mid-frame takes effect at the next LATCH.
- HEX outputs:
  - Registered, updated every cycle: HEXn <= blink_phase ? 7F : digit_reg_n.
  - Digits never show a partially converted value.
- Blink:
  - While alarm=1: the counter increments each cycle; at BLINK_CYCLES-1 it wraps to 0 and blink_phase toggles.
  - The first half-period is therefore visible.
  - alarm=0 at an edge: counter = 0 and phase = 0 on that edge; the display is visible on the next cycle.
  - Blinking does not stall conversion; frame_done still pulses while blanked.
- Widths:
  - Each converter uses a 12-bit BCD accumulator (hundreds/tens/ones) and a 3-bit shift counter.
  - No range check on hr (0..99 are shown as-is).

Decomposition:
- Shared package clock_disp_pkg:
  - FSM state enum (LATCH, SHIFT, COMMIT).
  - SEG_BLANK and SEG_DASH constants.
  - 16-entry seven-segment lookup function.
- Sub-module bcd_shift_converter:
  - Ports: clk, reset, load, shift_en, 8-bit bin, 12-bit bcd.
  - Instantiated three times.
  - Sequencing and the FSM stay in the top level.

Test Plan:
- Reset: reset=0 for 2 edges with arbitrary inputs -> all HEX=7F, frame_done=0; after release, the first frame_done occurs on the 11th edge.
- Time display: hr=7, min=22, sec=0, show_alarm=0 -> within 20 cycles HEX5..HEX0 = 40,78,24,24,40,40; frame_done pulses exactly every 10 cycles.
- Alarm view: hrA=7, minA=21, secA=0, toggle show_alarm=1 mid-SHIFT:
  - Current frame still shows 07:22:00.
  - Next frame shows 40,78,24,79,40,40.
- Boundaries:
  - hr=23, min=59, sec=255 -> HEX5..HEX0 = 24,30,12,10,3F,3F.
  - sec=100 -> dash on HEX1 and HEX0; sec=99 -> 10,10.
- Blink with BLINK_CYCLES=4: hold alarm=1 -> HEX alternates 4 cycles visible / 4 cycles all 7F; drop alarm=0 while blanked -> visible digits on the next cycle.
- Mid-operation reset: assert reset=0 during SHIFT cycle 4 -> HEX=7F on that edge; no frame_done until 10 edges after release; new values shown correctly.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared definitions for the clock display path: FSM encodings, special
// segment patterns and the BCD-digit to seven-segment lookup.
package clock_disp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t LATCH  = 2'd0;
  localparam state_t SHIFT  = 2'd1;
  localparam state_t COMMIT = 2'd2;

  // Segments are active-low, bit order gfedcba.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bcd_shift_converter.sv
// Sequential shift-add-3 binary to BCD converter: load captures the binary
// value, then eight shift_en cycles leave hundreds/tens/ones in bcd.
module bcd_shift_converter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        shift_en,
  input  logic [7:0]  bin,
  output logic [11:0] bcd
);

  logic [7:0]  bin_p0;
  logic [11:0] bcd_adj;

  function automatic logic [11:0] add3(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj = add3(bcd);

  // Hundreds never exceed 2 for an 8-bit input, so dropping the top bit is safe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_p0 <= '0;
      bcd    <= '0;
    end else if (load) begin
      bin_p0 <= bin;
      bcd    <= '0;
    end else if (shift_en) begin
      bin_p0 <= {bin_p0[6:0], 1'b0};
      bcd    <= 12'({bcd_adj, bin_p0[7]});
    end
  end

endmodule

// File: rtl/time_display_driver.sv
// Six-digit HH MM SS seven-segment driver: converts running or alarm time to
// BCD once per 10-cycle frame, commits all digits together, blinks on alarm.
module time_display_driver
  import clock_disp_pkg::*;
#(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sec,
  input  logic [7:0] min,
  input  logic [7:0] hr,
  input  logic [7:0] secA,
  input  logic [7:0] minA,
  input  logic [7:0] hrA,
  input  logic       show_alarm,
  input  logic       alarm,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       frame_done
);

  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

  state_t          state;
  logic [2:0]      shift_cnt;
  logic            load;
  logic            shift_en;
  logic [11:0]     bcd_sec;
  logic [11:0]     bcd_min;
  logic [11:0]     bcd_hr;
  logic [5:0][6:0] digit_p0;
  logic            commit_p0;
  logic [CNT_W-1:0] blink_cnt;
  logic            blink_phase;

  // Saturate out-of-range fields (three BCD digits) to a pair of dashes.
  function automatic logic [13:0] encode_field(input logic [11:0] b);
    if (b[11:8] != 4'd0) return {SEG_DASH, SEG_DASH};
    return {seg7(b[7:4]), seg7(b[3:0])};
  endfunction

  assign load     = (state == LATCH);
  assign shift_en = (state == SHIFT);

  bcd_shift_converter u_conv_sec (
    .clk(clk), .reset(reset), .load(load), .shift_en(shift_en),
    .bin(show_alarm ? secA : sec), .bcd(bcd_sec)
  );

  bcd_shift_converter u_conv_min (
    .clk(clk), .reset(reset), .load(load), .shift_en(shift_en),
    .bin(show_alarm ? minA : min), .bcd(bcd_min)
  );

  bcd_shift_converter u_conv_hr (
    .clk(clk), .reset(reset), .load(load), .shift_en(shift_en),
    .bin(show_alarm ? hrA : hr), .bcd(bcd_hr)
  );

  // Frame sequencer: LATCH (1) -> SHIFT (8) -> COMMIT (1)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LATCH;
      shift_cnt <= 3'd0;
      commit_p0 <= 1'b0;
    end else begin
      commit_p0 <= (state == COMMIT);
      case (state)
        LATCH: begin
          state     <= SHIFT;
          shift_cnt <= 3'd0;
        end
        SHIFT: begin
          shift_cnt <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd7) state <= COMMIT;
        end
        COMMIT:  state <= LATCH;
        default: state <= LATCH;
      endcase
    end
  end

  // Commit stage: all six digits change together, never mid-conversion
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_p0 <= {6{SEG_BLANK}};
    end else if (state == COMMIT) begin
      digit_p0 <= {encode_field(bcd_hr), encode_field(bcd_min), encode_field(bcd_sec)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || !alarm) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Output stage: frame_done lines up with the first cycle of the new digits
  always_ff @(posedge clk) begin
    if (!reset) begin
      HEX0       <= SEG_BLANK;
      HEX1       <= SEG_BLANK;
      HEX2       <= SEG_BLANK;
      HEX3       <= SEG_BLANK;
      HEX4       <= SEG_BLANK;
      HEX5       <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      HEX0       <= blink_phase ? SEG_BLANK : digit_p0[0];
      HEX1       <= blink_phase ? SEG_BLANK : digit_p0[1];
      HEX2       <= blink_phase ? SEG_BLANK : digit_p0[2];
      HEX3       <= blink_phase ? SEG_BLANK : digit_p0[3];
      HEX4       <= blink_phase ? SEG_BLANK : digit_p0[4];
      HEX5       <= blink_phase ? SEG_BLANK : digit_p0[5];
      frame_done <= commit_p0;
    end
  end

endmodule
